// File: rtl/ncl_wavefront_arbiter.sv
// Round-robin arbiter that sequences one DATA/NULL wavefront pair through a
// single-rail NCL pipeline on behalf of one of two requesters.
module ncl_wavefront_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done,
  output logic       pipe_in,
  input  logic       pipe_comp,
  input  logic       pipe_out,
  output logic       out_comp,
  output logic       err,
  output logic [7:0] wave_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_WOUT  = 3'd2,
    S_NULL  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_comp_sync;
  logic [SYNC_STAGES-1:0] r_out_sync;
  logic [15:0]            r_tmo;
  logic                   r_favor1;
  logic                   r_gnt0;
  logic                   r_gnt1;
  logic                   r_done;
  logic                   r_pipe_in;
  logic                   r_out_comp;
  logic                   r_err;
  logic [7:0]             r_wave_cnt;

  logic w_comp;
  logic w_pout;
  logic w_pick1;
  logic w_adv;
  logic w_waiting;
  logic w_timeout;

  // Both asynchronous pipeline signals are resynchronized before any use
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_comp_sync <= '0;
      r_out_sync  <= '0;
    end else begin
      r_comp_sync <= {r_comp_sync[SYNC_STAGES-2:0], pipe_comp};
      r_out_sync  <= {r_out_sync[SYNC_STAGES-2:0], pipe_out};
    end
  end

  assign w_comp  = r_comp_sync[SYNC_STAGES-1];
  assign w_pout  = r_out_sync[SYNC_STAGES-1];
  // req1 wins alone, or when both request and the pointer favors it
  assign w_pick1 = req1 & (~req0 | r_favor1);

  // Handshake condition that ends the current wait state
  always_comb begin
    w_adv     = 1'b0;
    w_waiting = 1'b0;
    case (r_state)
      S_DATA:  begin w_adv = w_comp;  w_waiting = 1'b1; end
      S_WOUT:  begin w_adv = w_pout;  w_waiting = 1'b1; end
      S_NULL:  begin w_adv = ~w_comp; w_waiting = 1'b1; end
      S_DRAIN: begin w_adv = ~w_pout; w_waiting = 1'b1; end
      default: begin w_adv = 1'b0;    w_waiting = 1'b0; end
    endcase
  end

  assign w_timeout = w_waiting & ~w_adv & (r_tmo == TMO_LAST);

  // Wavefront sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state    <= S_IDLE;
      r_tmo      <= 16'd0;
      r_favor1   <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done     <= 1'b0;
      r_pipe_in  <= 1'b0;
      r_out_comp <= 1'b0;
      r_err      <= 1'b0;
      r_wave_cnt <= 8'd0;
    end else if (w_timeout) begin
      r_state    <= S_ERR;
      r_tmo      <= 16'd0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done     <= 1'b0;
      r_pipe_in  <= 1'b0;
      r_out_comp <= 1'b0;
      r_err      <= 1'b1;
    end else begin
      if (w_waiting && !w_adv) begin
        r_tmo <= r_tmo + 16'd1;
      end else begin
        r_tmo <= 16'd0;
      end
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_state   <= S_DATA;
            r_pipe_in <= 1'b1;
            r_gnt0    <= ~w_pick1;
            r_gnt1    <= w_pick1;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_DATA: begin
          if (w_adv) begin
            r_state <= S_WOUT;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_WOUT: begin
          if (w_adv) begin
            r_state    <= S_NULL;
            r_pipe_in  <= 1'b0;
            r_out_comp <= 1'b1;
          end else begin
            r_state    <= S_WOUT;
          end
        end
        S_NULL: begin
          if (w_adv) begin
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_NULL;
          end
        end
        S_DRAIN: begin
          if (w_adv) begin
            r_state    <= S_DONE;
            r_out_comp <= 1'b0;
            r_done     <= 1'b1;
            r_wave_cnt <= r_wave_cnt + 8'd1;
            r_favor1   <= r_gnt0;
          end else begin
            r_state    <= S_DRAIN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state    <= S_IDLE;
          r_gnt0     <= 1'b0;
          r_gnt1     <= 1'b0;
          r_done     <= 1'b0;
          r_pipe_in  <= 1'b0;
          r_out_comp <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign done     = r_done;
  assign pipe_in  = r_pipe_in;
  assign out_comp = r_out_comp;
  assign err      = r_err;
  assign wave_cnt = r_wave_cnt;

endmodule

// File: tb/tb_ncl_wavefront_arbiter.sv
// Bench for ncl_wavefront_arbiter: phase-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_ncl_wavefront_arbiter;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       pipe_comp = 1'b0, pipe_out = 1'b0;
  logic       gnt0, gnt1, done, pipe_in, out_comp, err;
  logic [7:0] wave_cnt;

  int checks = 0;
  int fails  = 0;
  int n_done = 0;
  bit both_seen = 1'b0;
  bit stuck = 1'b0;
  bit gq[$];

  ncl_wavefront_arbiter #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .init_n(init_n), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .pipe_in(pipe_in),
    .pipe_comp(pipe_comp), .pipe_out(pipe_out), .out_comp(out_comp),
    .err(err), .wave_cnt(wave_cnt)
  );

  always #5 clk = ~clk;

  // Pipeline stand-in: completion follows pipe_in, tail output follows completion, 3 cycles each
  initial begin
    logic [2:0] dc;
    logic [2:0] dq;
    dc = 3'd0;
    dq = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      dc = {dc[1:0], pipe_in};
      pipe_comp = stuck ? 1'b0 : dc[2];
      dq = {dq[1:0], pipe_comp};
      pipe_out = dq[2];
    end
  end

  // Reference model: phase 0 idle, 1 data, 2 wait-out, 3 null, 4 drain, 5 done, 6 error
  int            m_phase;
  bit            m_owner;
  bit            m_last;
  logic [7:0]    m_cnt;
  int            m_wait;
  bit [SYNC-1:0] m_hc;
  bit [SYNC-1:0] m_ho;

  function automatic bit handshake(int ph, bit c, bit o);
    case (ph)
      1: return c;
      2: return o;
      3: return !c;
      4: return !o;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      m_phase <= 0; m_owner <= 1'b0; m_last <= 1'b1; m_cnt <= 8'd0;
      m_wait <= 0; m_hc <= '0; m_ho <= '0;
    end else begin
      m_hc <= {m_hc[SYNC-2:0], pipe_comp};
      m_ho <= {m_ho[SYNC-2:0], pipe_out};
      if (m_phase == 0) begin
        if (req0 || req1) begin
          m_owner <= (req0 && req1) ? !m_last : req1;
          m_phase <= 1;
          m_wait  <= 0;
        end
      end else if (m_phase >= 1 && m_phase <= 4) begin
        if (handshake(m_phase, m_hc[SYNC-1], m_ho[SYNC-1])) begin
          m_phase <= m_phase + 1;
          m_wait  <= 0;
          if (m_phase == 4) begin
            m_cnt  <= m_cnt + 8'd1;
            m_last <= m_owner;
          end
        end else if (m_wait + 1 >= TMO) begin
          m_phase <= 6;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (m_phase == 5) begin
        m_phase <= 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model's phase view
  always @(negedge clk) begin
    logic [13:0] exp_v, act_v;
    bit own;
    own = (m_phase >= 1 && m_phase <= 5);
    exp_v = {own && !m_owner, own && m_owner, (m_phase == 1 || m_phase == 2),
             (m_phase == 3 || m_phase == 4), (m_phase == 5), (m_phase == 6), m_cnt};
    act_v = {gnt0, gnt1, pipe_in, out_comp, done, err, wave_cnt};
    checks++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL cycle t=%0t got=%b want=%b (g0 g1 pin oc done err cnt)", $time, act_v, exp_v);
    end
    if (done === 1'b1) begin
      n_done++;
      gq.push_back(gnt1);
    end
    if (gnt0 === 1'b1 && gnt1 === 1'b1) both_seen = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; stuck = 1'b0;
    init_n = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1 init_n = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, n_done, target);
  endtask

  initial begin
    int base, gbase, k;

    // Reset state
    init_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", {gnt0, gnt1, done, pipe_in, out_comp, err}, 0);
    chk("reset_cnt", wave_cnt, 0);
    @(negedge clk);
    #1 init_n = 1'b1;

    // Single pair on req0
    base = n_done; gbase = gq.size();
    req0 = 1'b1;
    k = 0;
    while (gnt0 !== 1'b1 && k < 50) begin @(negedge clk); #1; k++; end
    chk("single_gnt0", gnt0, 1);
    req0 = 1'b0;
    wait_done(base + 1, 200, "single_done");
    repeat (4) @(negedge clk);
    chk("single_cnt", wave_cnt, 1);
    chk("single_owner", (gq.size() > gbase) ? gq[gbase] : 9, 0);
    chk("single_pulses", n_done - base, 1);

    // Both requesting for four pairs alternates starting at req0
    do_reset();
    base = n_done; gbase = gq.size();
    req0 = 1'b1; req1 = 1'b1;
    wait_done(base + 4, 800, "rr_done");
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk("rr_owner", (gq.size() > gbase + i) ? gq[gbase + i] : 9, i % 2);
    chk("rr_cnt", wave_cnt, 4);
    chk("rr_onehot", both_seen, 0);

    // Request dropped during NULL still completes; nothing granted afterwards
    do_reset();
    base = n_done;
    req0 = 1'b1;
    k = 0;
    while (!(out_comp === 1'b1 && pipe_in === 1'b0) && k < 100) begin @(negedge clk); #1; k++; end
    chk("drop_in_null", out_comp, 1);
    req0 = 1'b0;
    wait_done(base + 1, 200, "drop_done");
    repeat (10) @(negedge clk);
    chk("drop_idle_gnt", {gnt0, gnt1}, 0);
    chk("drop_cnt", wave_cnt, 1);

    // Reset during WOUT aborts without a done pulse
    do_reset();
    base = n_done;
    req0 = 1'b1;
    k = 0;
    while (m_phase != 2 && k < 100) begin @(negedge clk); #1; k++; end
    chk("abort_reach_wout", m_phase, 2);
    @(posedge clk);
    #2 init_n = 1'b0;
    #1;
    chk("abort_outs", {gnt0, gnt1, done, pipe_in, out_comp, err}, 0);
    chk("abort_cnt", wave_cnt, 0);
    chk("abort_no_done", n_done - base, 0);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    #1 init_n = 1'b1;

    // Stuck completion in DATA: error exactly 16 cycles after entry
    do_reset();
    stuck = 1'b1;
    req0 = 1'b1;
    k = 0;
    while (gnt0 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("tmo_gnt", gnt0, 1);
    repeat (15) @(negedge clk);
    chk("tmo_before", err, 0);
    @(negedge clk);
    chk("tmo_err", err, 1);
    chk("tmo_outs", {pipe_in, gnt0, gnt1, out_comp, done}, 0);
    req0 = 1'b0;
    stuck = 1'b0;
    repeat (20) @(negedge clk);
    chk("tmo_sticky", err, 1);
    do_reset();
    @(negedge clk);
    chk("tmo_cleared", err, 0);

    // 256 back-to-back pairs on req1 wrap the counter
    base = n_done;
    req1 = 1'b1;
    wait_done(base + 255, 255 * 80, "wrap_255");
    chk("wrap_cnt255", wave_cnt, 255);
    wait_done(base + 256, 80, "wrap_256");
    req1 = 1'b0;
    chk("wrap_cnt0", wave_cnt, 0);
    repeat (4) @(negedge clk);
    chk("wrap_pulses", n_done - base, 256);
    chk("wrap_err", err, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ncl_wavefront_arbiter.md
NCL_WAVEFRONT_ARBITER -- requirements
Module: ncl_wavefront_arbiter

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer; legal range 2..4.
REQ-002 Parameter TIMEOUT, default 255: cycles permitted per wait state before error; legal range 1..65535.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 init_n  input  1  asynchronous active-low reset.
REQ-006 req0  input  1  requester 0 level request for one DATA/NULL wavefront pair.
REQ-007 req1  input  1  requester 1 level request, same meaning.
REQ-008 gnt0  output  1  requester 0 owns the pipeline.
REQ-009 gnt1  output  1  requester 1 owns the pipeline.
REQ-010 done  output  1  one-cycle pulse: granted wavefront pair fully completed.
REQ-011 pipe_in  output  1  single-rail pipeline input: 1 = DATA, 0 = NULL.
REQ-012 pipe_comp  input  1  asynchronous completion from pipeline input stage (ACOMP of first fanout component).
REQ-013 pipe_out  input  1  asynchronous single-rail pipeline output (fanin tail).
REQ-014 out_comp  output  1  completion returned to pipeline tail stage.
REQ-015 err  output  1  sticky timeout flag.
REQ-016 wave_cnt  output  8  completed pair count.

Function
REQ-017 pipe_comp and pipe_out SHALL each pass through a SYNC_STAGES-deep synchronizer before use; no other logic reads them raw.
REQ-018 FSM states: IDLE, DATA, WOUT, NULL, DRAIN, DONE, ERR.
REQ-019 IDLE: pipe_in=0, out_comp=0, grants low; if any req high, next cycle enter DATA with the arbitrated grant high.
REQ-020 Arbitration SHALL be round-robin: single request wins; both high wins the requester not granted last; pointer after reset favors req0.
REQ-021 Grant SHALL stay one-hot and constant from DATA entry through DONE; requests are ignored (including drops) outside IDLE.
REQ-022 DATA: pipe_in=1; exit to WOUT when synchronized pipe_comp=1.
REQ-023 WOUT: pipe_in=1; when synchronized pipe_out=1, set out_comp=1 and enter NULL next cycle.
REQ-024 NULL: pipe_in=0, out_comp=1; exit to DRAIN when synchronized pipe_comp=0.
REQ-025 DRAIN: pipe_in=0; when synchronized pipe_out=0, clear out_comp and enter DONE.
REQ-026 DONE: exactly one cycle; done=1, wave_cnt increments modulo 256 (255 wraps to 0), round-robin pointer updates, grants drop on exit to IDLE.
REQ-027 Consecutive pairs: a pending req in DONE SHALL be serviced via IDLE; minimum one IDLE cycle between pairs.
REQ-028 Per-state timeout counter SHALL clear on each state entry; in DATA, WOUT, NULL, DRAIN, reaching TIMEOUT cycles enters ERR.
REQ-029 ERR: err=1, pipe_in=0, out_comp=0, grants low, done low; remains until reset.
REQ-030 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-031 init_n low SHALL asynchronously force IDLE, pipe_in=0, out_comp=0, gnt0=gnt1=0, done=0, err=0, wave_cnt=0, synchronizers 0, pointer favoring req0.
REQ-032 Reset asserted mid-pair SHALL abort immediately with no done pulse and no wave_cnt increment; deassertion takes effect at the next rising clk edge.

Verification
REQ-033 req0=1 alone, pipeline model with 3-cycle response per transition -> gnt0=1, pipe_in 1 then 0, out_comp 1 then 0, one done pulse, wave_cnt=1.
REQ-034 req0=req1=1 held for four pairs -> grants alternate gnt0,gnt1,gnt0,gnt1; wave_cnt=4; never both grants high.
REQ-035 pipe_comp stuck 0 with TIMEOUT=16 in DATA -> ERR on cycle 16 after DATA entry, err=1, pipe_in=0, gnt0=0, holds until init_n pulse.
REQ-036 init_n pulsed low during WOUT -> all outputs reset immediately, no done, wave_cnt unchanged at 0.
REQ-037 256 back-to-back pairs on req1 -> wave_cnt returns to 0, 256 done pulses, err=0.
REQ-038 req0 dropped during NULL -> pair completes normally with done pulse; subsequent IDLE grants nothing.
